// File: rtl/heap_sort_pkg.sv
// heap_sort_pkg: shared constants, state type and command packing for the heap-sort step
package heap_sort_pkg;
  localparam int DATA_W = 32;
  localparam int N_ELEM = 5;
  localparam int CNT_W = 3;
  localparam int VEC_W = N_ELEM * DATA_W;
  localparam int CMD_W = 197;
  localparam logic [DATA_W-1:0] PAD_VAL = 32'h7FFF_FFFF;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b100;
  typedef enum logic [1:0] {COLLECT, LOAD, WAIT} feeder_state_t;
  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [2:0] op,
    input logic top_v,
    input logic [DATA_W-1:0] top,
    input logic ld_v,
    input logic [VEC_W-1:0] vec
  );
    return {op, top_v, top, ld_v, vec};
  endfunction
endpackage

// File: rtl/heap_sort_word_packer.sv
// heap_sort_word_packer: batch vector register with slot write and flush padding
module heap_sort_word_packer
  import heap_sort_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  slot,
  input  logic             pad_en,
  input  logic [CNT_W-1:0]  fill,
  output logic [VEC_W-1:0]  vec_o
);
  logic [VEC_W-1:0] vec_q, vec_d;
  // word k sits MSB-first; on flush every slot at or beyond the fill count gets the pad word
  always_comb begin
    vec_d = vec_q;
    for (int i = 0; i < N_ELEM; i++)
      vec_d[VEC_W-1-DATA_W*i -: DATA_W] = (wr_en && slot == CNT_W'(i)) ? wr_data :
                                          (pad_en && CNT_W'(i) >= fill) ? PAD_VAL :
                                          vec_q[VEC_W-1-DATA_W*i -: DATA_W];
  end
  // vector register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vec_q <= '0;
    else vec_q <= vec_d;
  assign vec_o = vec_d;
endmodule

// File: rtl/heap_sort_cmd_feeder.sv
// heap_sort_cmd_feeder: packs input words into batches and issues LOAD commands to the sorter
module heap_sort_cmd_feeder
  import heap_sort_pkg::*;
(
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_data_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  input  logic                     sorter_idle_i,
  output logic [CMD_W-1:0]         cmd_o,
  output logic [CNT_W-1:0]         batch_len_o,
  output logic                     busy_o
);
  feeder_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_nxt;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic ready_q, ready_d, busy_q, busy_d;
  logic xfer, full, do_flush, go_load;
  logic [VEC_W-1:0] vec_nxt;
  heap_sort_word_packer u_packer (
    .clk    (system1000),
    .rst_n  (system1000_rstn),
    .wr_en  (xfer),
    .wr_data(in_data_i),
    .slot   (cnt_q),
    .pad_en (do_flush),
    .fill   (cnt_nxt),
    .vec_o  (vec_nxt)
  );
  // next-state, counter and registered-output logic; the LOAD command is built from the vector as it will be after this edge
  always_comb begin
    xfer = in_valid_i & ready_q;
    cnt_nxt = cnt_q + CNT_W'(xfer);
    full = xfer && cnt_q == CNT_W'(N_ELEM - 1);
    do_flush = flush_i && state_q == COLLECT && cnt_nxt != '0;
    go_load = full || do_flush;
    state_d = state_q == COLLECT ? (go_load ? LOAD : COLLECT) :
              state_q == LOAD ? WAIT : (sorter_idle_i ? COLLECT : WAIT);
    cnt_d = (state_q == COLLECT && !go_load) ? cnt_nxt : '0;
    len_d = go_load ? cnt_nxt : len_q;
    cmd_d = go_load ? pack_cmd(OP_LOAD, 1'b0, '0, 1'b1, vec_nxt) : pack_cmd(OP_NOP, 1'b0, '0, 1'b0, '0);
    ready_d = state_d == COLLECT;
    busy_d = state_d != COLLECT;
  end
  // FSM state and registered outputs
  always_ff @(posedge system1000 or negedge system1000_rstn)
    if (!system1000_rstn) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      len_q <= '0;
      cmd_q <= pack_cmd(OP_NOP, 1'b0, '0, 1'b0, '0);
      ready_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      cmd_q <= cmd_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  assign in_ready_o = ready_q;
  assign cmd_o = cmd_q;
  assign batch_len_o = len_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_heap_sort_cmd_feeder.sv
// tb_heap_sort_cmd_feeder: directed table, corner sequences and random batches against a queue model
module tb_heap_sort_cmd_feeder;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid_i = 0;
  logic flush_i = 0;
  logic sorter_idle_i = 0;
  logic [31:0] in_data_i = 0;
  logic in_ready_o, busy_o;
  logic [196:0] cmd_o;
  logic [2:0] batch_len_o;
  int tests = 0;
  int fails = 0;
  localparam logic [31:0] P = 32'h7FFF_FFFF;
  localparam logic [196:0] NOP = '0;

  always #5 clk = ~clk;

  heap_sort_cmd_feeder dut (
    .system1000(clk),
    .system1000_rstn(rst_n),
    .in_valid_i(in_valid_i),
    .in_data_i(in_data_i),
    .in_ready_o(in_ready_o),
    .flush_i(flush_i),
    .sorter_idle_i(sorter_idle_i),
    .cmd_o(cmd_o),
    .batch_len_o(batch_len_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic v; logic [31:0] d; logic fl; logic idle;
    logic er; logic [196:0] ecmd; logic [2:0] elen; logic eb;
  } vec_t;
  vec_t tbl[18];

  // reference model: 0 collecting, 1 load shown, 2 waiting for sorter
  int mode = 0;
  int loads = 0;
  logic [31:0] q[$];
  logic [159:0] m_vec = '0;
  logic [2:0] m_len = '0;

  function automatic logic [196:0] load_cmd(logic [159:0] v);
    return {3'b100, 1'b0, 32'b0, 1'b1, v};
  endfunction

  function automatic vec_t mk(logic v, logic [31:0] d, logic fl, logic idle,
                              logic er, logic [196:0] ecmd, logic [2:0] elen, logic eb);
    vec_t r;
    r.v = v; r.d = d; r.fl = fl; r.idle = idle;
    r.er = er; r.ecmd = ecmd; r.elen = elen; r.eb = eb;
    return r;
  endfunction

  task automatic chk(string n, logic [196:0] a, logic [196:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    mode = 0;
    q.delete();
    m_len = '0;
  endtask

  task automatic model_edge(logic v, logic [31:0] d, logic fl, logic idle);
    if (mode == 0) begin
      if (v) q.push_back(d);
      if (q.size() == 5 || (fl && q.size() > 0)) begin
        m_len = 3'(q.size());
        for (int k = 0; k < 5; k++) m_vec[159-32*k -: 32] = k < q.size() ? q[k] : P;
        q.delete();
        mode = 1;
        loads++;
      end
    end else if (mode == 1) mode = 2;
    else if (idle) mode = 0;
  endtask

  task automatic check_model();
    chk("ready", {196'b0, in_ready_o}, {196'b0, mode == 0});
    chk("busy", {196'b0, busy_o}, {196'b0, mode != 0});
    chk("len", {194'b0, batch_len_o}, {194'b0, m_len});
    chk("cmd", cmd_o, mode == 1 ? load_cmd(m_vec) : NOP);
  endtask

  task automatic step(logic v, logic [31:0] d, logic fl, logic idle);
    in_valid_i = v; in_data_i = d; flush_i = fl; sorter_idle_i = idle;
    @(posedge clk);
    model_edge(v, d, fl, idle);
    @(negedge clk);
    check_model();
  endtask

  task automatic quiet_inputs();
    in_valid_i = 0; flush_i = 0; sorter_idle_i = 0;
  endtask

  initial begin
    // directed table: word streams, flush padding, same-cycle flush, flush ignored cases
    tbl[0]  = mk(1, 32'd5,  0, 0, 1, NOP, 0, 0);
    tbl[1]  = mk(1, 32'hFFFF_FFFD, 0, 0, 1, NOP, 0, 0);
    tbl[2]  = mk(1, 32'd9,  0, 0, 1, NOP, 0, 0);
    tbl[3]  = mk(1, 32'd0,  0, 0, 1, NOP, 0, 0);
    tbl[4]  = mk(1, 32'd7,  0, 0, 0, load_cmd({32'd5, 32'hFFFF_FFFD, 32'd9, 32'd0, 32'd7}), 5, 1);
    tbl[5]  = mk(1, 32'd99, 0, 1, 0, NOP, 5, 1);
    tbl[6]  = mk(0, 32'd0,  0, 1, 1, NOP, 5, 0);
    tbl[7]  = mk(1, 32'd4,  0, 0, 1, NOP, 5, 0);
    tbl[8]  = mk(1, 32'hFFFF_FFFF, 0, 0, 1, NOP, 5, 0);
    tbl[9]  = mk(0, 32'd0,  1, 0, 0, load_cmd({32'd4, 32'hFFFF_FFFF, P, P, P}), 2, 1);
    tbl[10] = mk(0, 32'd0,  1, 0, 0, NOP, 2, 1);
    tbl[11] = mk(0, 32'd0,  0, 1, 1, NOP, 2, 0);
    tbl[12] = mk(0, 32'd0,  1, 0, 1, NOP, 2, 0);
    tbl[13] = mk(1, 32'd10, 0, 0, 1, NOP, 2, 0);
    tbl[14] = mk(1, 32'd20, 0, 0, 1, NOP, 2, 0);
    tbl[15] = mk(1, 32'd30, 1, 0, 0, load_cmd({32'd10, 32'd20, 32'd30, P, P}), 3, 1);
    tbl[16] = mk(0, 32'd0,  0, 1, 0, NOP, 3, 1);
    tbl[17] = mk(0, 32'd0,  0, 1, 1, NOP, 3, 0);

    repeat (2) @(negedge clk);
    chk("rst_cmd", cmd_o, NOP);
    chk("rst_ready", {196'b0, in_ready_o}, 197'd1);
    chk("rst_len", {194'b0, batch_len_o}, '0);
    chk("rst_busy", {196'b0, busy_o}, '0);
    rst_n = 1;
    model_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].idle);
      chk($sformatf("tbl%0d_ready", i), {196'b0, in_ready_o}, {196'b0, tbl[i].er});
      chk($sformatf("tbl%0d_cmd", i), cmd_o, tbl[i].ecmd);
      chk($sformatf("tbl%0d_len", i), {194'b0, batch_len_o}, {194'b0, tbl[i].elen});
      chk($sformatf("tbl%0d_busy", i), {196'b0, busy_o}, {196'b0, tbl[i].eb});
    end

    // long sorter stall: nothing accepted, NOP throughout, ready returns one cycle after idle
    for (int i = 0; i < 5; i++) step(1, 32'd100 + 32'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'hDEAD_0000 + 32'(i), 0, 0);
      chk("stall_cmd", cmd_o, NOP);
      chk("stall_ready", {196'b0, in_ready_o}, '0);
    end
    step(0, 0, 0, 1);
    chk("stall_release", {196'b0, in_ready_o}, 197'd1);
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, 0);
    chk("after_stall", cmd_o, load_cmd({32'd1, 32'd2, 32'd3, 32'd4, 32'd5}));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // async reset mid-batch discards the partial words
    for (int i = 0; i < 3; i++) step(1, 32'd11 + 32'(i), 0, 0);
    quiet_inputs();
    #2 rst_n = 0;
    #1 chk("midrst_ready", {196'b0, in_ready_o}, 197'd1);
    chk("midrst_len", {194'b0, batch_len_o}, '0);
    @(negedge clk) rst_n = 1;
    model_reset();
    for (int i = 0; i < 5; i++) step(1, 32'd21 + 32'(i), 0, 0);
    chk("postrst_load", cmd_o, load_cmd({32'd21, 32'd22, 32'd23, 32'd24, 32'd25}));
    chk("postrst_len", {194'b0, batch_len_o}, 197'd5);

    // async reset while LOAD is on the bus withdraws it immediately
    quiet_inputs();
    #2 rst_n = 0;
    #1 chk("withdraw_cmd", cmd_o, NOP);
    chk("withdraw_busy", {196'b0, busy_o}, '0);
    chk("withdraw_ready", {196'b0, in_ready_o}, 197'd1);
    @(negedge clk) rst_n = 1;
    model_reset();

    // random gaps, flushes and sorter stalls over 100 batches
    begin
      int start;
      int cyc;
      start = loads;
      cyc = 0;
      while (loads - start < 100 && cyc < 20000) begin
        step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
        cyc++;
      end
      tests++;
      if (loads - start < 100) begin
        fails++;
        $display("FAIL rand_budget: got %0d batches required 100", loads - start);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
